// File: rtl/tx_uart.sv
// tx_uart: buffered 8N1 serial transmitter.
//
// Bytes written through data_wr/data_in are queued in a small FIFO and sent
// LSB first as 1 start bit (0), 8 data bits, 1 stop bit (1). Each bit lasts
// CPS = SYSTEM_CLK / BAUDRATE clock cycles. Queued frames are sent back to
// back with no idle time between a stop bit and the next start bit.
//
// Parameters:
//   SYSTEM_CLK  clock frequency in Hz
//   BAUDRATE    line rate in bit/s (SYSTEM_CLK / BAUDRATE must be >= 2)
//   FIFO_DEPTH  transmit FIFO entries (power of two, >= 2)
//
// Ports:
//   clk       system clock, rising edge
//   resetn    synchronous active-low reset
//   data_wr   one-cycle write strobe
//   data_in   byte to queue, sampled when data_wr = 1
//   tx_out    registered serial line, idle high
//   ready     FIFO not full, a write this cycle will be accepted
//   busy      a frame is in progress or the FIFO holds data
//   level     current FIFO occupancy, 0..FIFO_DEPTH
//   overflow  sticky: a write was dropped because the FIFO was full
module tx_uart #(
  parameter int SYSTEM_CLK = 100_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          resetn,
  input  logic                          data_wr,
  input  logic [7:0]                    data_in,
  output logic                          tx_out,
  output logic                          ready,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow
);

  localparam int CPS   = SYSTEM_CLK / BAUDRATE;
  localparam int CNT_W = $clog2(SYSTEM_CLK);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CPS - 1);
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t state;
  state_t next_state;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;

  logic [CNT_W-1:0] cyc_cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shreg;
  logic             line_bit;

  logic fifo_empty;
  logic fifo_full;
  logic bit_done;
  logic pop;
  logic push;

  assign fifo_empty = (level == '0);
  assign fifo_full  = (level == FULL_LVL);
  assign bit_done   = (cyc_cnt == LAST_CNT);

  // A new frame starts either from idle or exactly at the end of the stop
  // bit, which is what makes consecutive frames seamless.
  assign pop  = !fifo_empty && ((state == IDLE) || ((state == STOP) && bit_done));

  // Fullness is judged before the edge: a pop on the same edge does not
  // make room for a write to a full FIFO.
  assign push = data_wr && !fifo_full;

  assign ready = !fifo_full;
  assign busy  = (state != IDLE) || !fifo_empty;

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= data_in;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag. Pointers wrap
  // naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        level <= level + LVL_W'(1);
      end else if (pop && !push) begin
        level <= level - LVL_W'(1);
      end
      if (data_wr && fifo_full) begin
        overflow <= 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Bit timing and shift register. A pop reloads everything on the same
  // edge, so the start bit of the new frame gets its full CPS cycles.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cyc_cnt <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else if (pop) begin
      shreg   <= mem[rd_ptr];
      cyc_cnt <= '0;
      bit_idx <= '0;
    end else if (state != IDLE) begin
      if (bit_done) begin
        cyc_cnt <= '0;
        if (state == DATA) begin
          shreg   <= {1'b0, shreg[7:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end else begin
        cyc_cnt <= cyc_cnt + CNT_W'(1);
      end
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          next_state = START;
        end
      end
      START: begin
        if (bit_done) begin
          next_state = DATA;
        end
      end
      DATA: begin
        if (bit_done && (bit_idx == 3'd7)) begin
          next_state = STOP;
        end
      end
      STOP: begin
        if (bit_done) begin
          next_state = fifo_empty ? IDLE : START;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Line value for the current state; the data bit is always shreg[0].
  always_comb begin
    line_bit = 1'b1;
    case (state)
      IDLE:    line_bit = 1'b1;
      START:   line_bit = 1'b0;
      DATA:    line_bit = shreg[0];
      STOP:    line_bit = 1'b1;
      default: line_bit = 1'b1;
    endcase
  end

  // Registered line output: glitch-free and one cycle behind the state,
  // which puts the first start bit two edges after the write.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      tx_out <= 1'b1;
    end else begin
      tx_out <= line_bit;
    end
  end

endmodule

// File: tb/tb_tx_uart.sv
// tb_tx_uart: self-checking bench for tx_uart with CPS = 10, FIFO_DEPTH = 4.
// A frame-level reference model (FIFO queue plus a countdown of the cycles
// left in the frame being sent) predicts every output on every cycle; a
// behavioural receiver decodes the line during the loopback phase.
module tb_tx_uart;

  localparam int SYS_CLK = 1_000_000;
  localparam int BAUD    = 100_000;
  localparam int DEPTH   = 4;
  localparam int CPS     = SYS_CLK / BAUD;
  localparam int FRAME   = 10 * CPS;
  localparam int LVL_W   = $clog2(DEPTH) + 1;

  logic             clk     = 1'b0;
  logic             resetn  = 1'b0;
  logic             data_wr = 1'b0;
  logic [7:0]       data_in = 8'h00;
  logic             tx_out;
  logic             ready;
  logic             busy;
  logic [LVL_W-1:0] level;
  logic             overflow;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // reference model state
  logic [7:0] m_q[$];
  int         m_rem       = 0;
  int         m_pos       = 0;
  logic [7:0] m_cur       = 8'h00;
  logic       m_over      = 1'b0;
  logic       m_tx        = 1'b1;
  logic       m_line      = 1'b1;
  logic       model_valid = 1'b0;
  logic       full_pre;
  logic       can_pop;

  // loopback receiver state
  logic       rx_en   = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic [7:0] rx_q[$];
  logic [7:0] sent_q[$];

  logic [9:0]  exp_a5;
  logic [29:0] exp_three;
  logic [3:0]  idx4;
  logic [4:0]  idx5;

  tx_uart #(
    .SYSTEM_CLK(SYS_CLK),
    .BAUDRATE  (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .data_wr (data_wr),
    .data_in (data_in),
    .tx_out  (tx_out),
    .ready   (ready),
    .busy    (busy),
    .level   (level),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Drive inputs for one clock edge, then return 1 time unit after it.
  task automatic applyStimulus(input logic wr, input logic [7:0] b);
    data_wr = wr;
    data_in = b;
    @(posedge clk);
    #1;
    data_wr = 1'b0;
  endtask

  task automatic doReset();
    resetn = 1'b0;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    resetn = 1'b1;
  endtask

  task automatic waitIdle();
    for (int w = 0; w < 3000; w++) begin
      if (!busy) break;
      applyStimulus(1'b0, 8'h00);
    end
    if (busy) checkOutput("idle_timeout", 32'(busy), 0);
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
  endtask

  // Line value of a frame: slot 0 start, slots 1..8 data LSB first, 9 stop.
  function automatic logic lineValue(input int rem, input int p, input logic [7:0] b);
    int         slot;
    logic [7:0] t;
    if (rem == 0) return 1'b1;
    slot = p / CPS;
    if (slot == 0) return 1'b0;
    if (slot >= 9) return 1'b1;
    t = b >> (slot - 1);
    return t[0];
  endfunction

  // Reference model, advanced on every rising edge with pre-edge inputs.
  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (!resetn) begin
        m_q.delete();
        m_rem       = 0;
        m_pos       = 0;
        m_over      = 1'b0;
        m_tx        = 1'b1;
        m_line      = 1'b1;
        model_valid = 1'b1;
      end else begin
        full_pre = (m_q.size() == DEPTH);
        can_pop  = (m_q.size() > 0) && (m_rem <= 1);
        m_tx     = m_line;
        if (can_pop) begin
          m_cur = m_q.pop_front();
          m_rem = FRAME;
          m_pos = 0;
        end else if (m_rem > 0) begin
          m_rem--;
          m_pos++;
        end
        if (data_wr) begin
          if (full_pre) m_over = 1'b1;
          else m_q.push_back(data_in);
        end
        m_line = lineValue(m_rem, m_pos, m_cur);
      end
    end
  end

  // Compare every output against the model on each falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        checkOutput("tx_out",   32'(tx_out),   32'(m_tx));
        checkOutput("level",    32'(level),    m_q.size());
        checkOutput("ready",    32'(ready),    32'(m_q.size() != DEPTH));
        checkOutput("busy",     32'(busy),     32'((m_rem > 0) || (m_q.size() > 0)));
        checkOutput("overflow", 32'(overflow), 32'(m_over));
      end
    end
  end

  // Behavioural 8N1 receiver sampling mid-bit.
  initial begin
    forever begin
      @(negedge clk);
      if (rx_en && (tx_out === 1'b0)) begin
        repeat (CPS / 2) @(negedge clk);
        checkOutput("rx_start", 32'(tx_out), 0);
        for (int i = 0; i < 8; i++) begin
          repeat (CPS) @(negedge clk);
          rx_byte = {tx_out, rx_byte[7:1]};
        end
        repeat (CPS) @(negedge clk);
        checkOutput("rx_stop", 32'(tx_out), 1);
        rx_q.push_back(rx_byte);
      end
    end
  end

  initial begin
    #1_500_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    exp_a5    = 10'b1101001010;
    exp_three = {10'b1010101010, 10'b1111111110, 10'b1000000000};

    // reset state
    doReset();
    checkOutput("rst_tx",    32'(tx_out),   1);
    checkOutput("rst_level", 32'(level),    0);
    checkOutput("rst_ready", 32'(ready),    1);
    checkOutput("rst_busy",  32'(busy),     0);
    checkOutput("rst_ovf",   32'(overflow), 0);

    // single byte 0xA5: latency and bit pattern
    applyStimulus(1'b1, 8'hA5);
    checkOutput("a5_tx_n",    32'(tx_out), 1);
    checkOutput("a5_level_n", 32'(level),  1);
    applyStimulus(1'b0, 8'h00);
    checkOutput("a5_tx_n1",   32'(tx_out), 1);
    checkOutput("a5_lvl_n1",  32'(level),  0);
    applyStimulus(1'b0, 8'h00);
    for (int k = 0; k < 100; k++) begin
      idx4 = 4'(k / 10);
      checkOutput("a5_line", 32'(tx_out), 32'(exp_a5[idx4]));
      if (k == 98) checkOutput("a5_busy_n100", 32'(busy), 1);
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("a5_busy_n102", 32'(busy), 0);
    waitIdle();

    // three consecutive writes: back-to-back frames
    applyStimulus(1'b1, 8'h00);
    applyStimulus(1'b1, 8'hFF);
    applyStimulus(1'b1, 8'h55);
    checkOutput("b2b_level", 32'(level), 2);
    for (int k = 0; k < 300; k++) begin
      idx5 = 5'(k / 10);
      checkOutput("b2b_line", 32'(tx_out), 32'(exp_three[idx5]));
      if (k == 298) checkOutput("b2b_busy_end", 32'(busy), 1);
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("b2b_busy_after", 32'(busy), 0);
    waitIdle();

    // fill the FIFO with continuous writes, sixth write dropped
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, 8'($urandom));
      if (i == 1) checkOutput("fill_lvl_n1", 32'(level), 1);
      if (i == 4) begin
        checkOutput("fill_lvl_n4",   32'(level),    4);
        checkOutput("fill_ready_n4", 32'(ready),    0);
        checkOutput("fill_ovf_n4",   32'(overflow), 0);
      end
      if (i == 5) begin
        checkOutput("fill_lvl_n5",   32'(level),    4);
        checkOutput("fill_ovf_n5",   32'(overflow), 1);
        checkOutput("fill_ready_n5", 32'(ready),    0);
      end
    end
    waitIdle();

    // random traffic, including writes dropped on full
    for (int i = 0; i < 400; i++) begin
      applyStimulus($urandom_range(0, 3) == 0, 8'($urandom));
    end
    waitIdle();

    // write to a full FIFO on the same edge as the stop-end pop
    doReset();
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 8'($urandom));
    repeat (96) applyStimulus(1'b0, 8'h00);
    checkOutput("pop_full_lvl_pre", 32'(level),    4);
    checkOutput("pop_full_ovf_pre", 32'(overflow), 0);
    applyStimulus(1'b1, 8'h3C);
    checkOutput("pop_full_lvl",   32'(level),    3);
    checkOutput("pop_full_ovf",   32'(overflow), 1);
    checkOutput("pop_full_ready", 32'(ready),    1);
    waitIdle();

    // reset during data bit 3 with two bytes queued
    for (int i = 0; i < 3; i++) applyStimulus(1'b1, 8'($urandom));
    checkOutput("abort_lvl_pre", 32'(level), 2);
    repeat (42) applyStimulus(1'b0, 8'h00);
    resetn = 1'b0;
    applyStimulus(1'b0, 8'h00);
    resetn = 1'b1;
    checkOutput("abort_tx",    32'(tx_out),   1);
    checkOutput("abort_level", 32'(level),    0);
    checkOutput("abort_busy",  32'(busy),     0);
    checkOutput("abort_ovf",   32'(overflow), 0);
    for (int k = 0; k < 300; k++) begin
      applyStimulus(1'b0, 8'h00);
      checkOutput("abort_quiet_tx",   32'(tx_out), 1);
      checkOutput("abort_quiet_busy", 32'(busy),   0);
    end

    // loopback of 256 random bytes through the receiver
    rx_en = 1'b1;
    for (int n = 0; n < 256; n++) begin
      logic [7:0] b;
      for (int w = 0; w < 500; w++) begin
        if (ready) break;
        applyStimulus(1'b0, 8'h00);
      end
      if (!ready) checkOutput("ready_wait", 32'(ready), 1);
      b = 8'($urandom);
      applyStimulus(1'b1, b);
      sent_q.push_back(b);
      repeat ($urandom_range(0, 2)) applyStimulus(1'b0, 8'h00);
    end
    for (int w = 0; w < 3000; w++) begin
      if (rx_q.size() >= 256) break;
      applyStimulus(1'b0, 8'h00);
    end
    checkOutput("rx_count", rx_q.size(), 256);
    for (int i = 0; i < rx_q.size() && i < 256; i++) begin
      checkOutput("rx_byte", 32'(rx_q[i]), 32'(sent_q[i]));
    end
    rx_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tx_uart.md
TX_UART -- requirements
Module: tx_uart

Interface
REQ-001 The block SHALL have parameter SYSTEM_CLK, default 100_000_000, meaning clock frequency in Hz.
REQ-002 The block SHALL have parameter BAUDRATE, default 9600, meaning line rate in bit/s.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 16, meaning transmit FIFO entries; power of two, >=2.
REQ-004 The block SHALL have port clk, input, 1, meaning system clock; all logic on its rising edge.
REQ-005 The block SHALL have port resetn, input, 1, meaning reset: synchronous, active-low.
REQ-006 The block SHALL have port data_wr, input, 1, meaning one-cycle write strobe.
REQ-007 The block SHALL have port data_in, input, 8, meaning byte to queue, sampled when data_wr=1.
REQ-008 The block SHALL have port tx_out, output, 1, meaning serial line; idle high.
REQ-009 The block SHALL have port ready, output, 1, meaning FIFO not full (write will be accepted).
REQ-010 The block SHALL have port busy, output, 1, meaning a frame is on the line or the FIFO is non-empty.
REQ-011 The block SHALL have port level, output, $clog2(FIFO_DEPTH)+1, meaning current FIFO occupancy.
REQ-012 The block SHALL have port overflow, output, 1, meaning sticky flag: a write was dropped.

Function
REQ-013 The block SHALL use CPS = floor(SYSTEM_CLK/BAUDRATE) cycles per bit; counter width $clog2(SYSTEM_CLK); CPS>=2 is required.
REQ-014 The block SHALL send frames of 1 start bit (0), 8 data bits LSB first, 1 stop bit (1), no parity; each bit driven exactly CPS cycles.
REQ-015 The block SHALL use FSM states IDLE, START, DATA, STOP; IDLE->START on pop, START->DATA after CPS cycles, DATA->STOP after 8th bit's CPS cycles, STOP->START (FIFO non-empty) or IDLE (empty) after CPS cycles.
REQ-016 The block SHALL pop the FIFO only in IDLE with FIFO non-empty, or in the last STOP cycle with FIFO non-empty; popped byte loads the shift register in the same edge.
REQ-017 The block SHALL have latency: byte written at edge N into empty FIFO while IDLE -> tx_out low from edge N+2.
REQ-018 The block SHALL place back-to-back frames with zero idle cycles: stop bit exactly CPS cycles, next start bit immediately follows.
REQ-019 The block SHALL register tx_out (no combinational path from any input); tx_out=1 in IDLE.
REQ-020 The block SHALL drop a write when full (ready=0 pre-edge), even if a pop occurs on the same edge; the drop sets overflow=1.
REQ-021 The block SHALL treat simultaneous write and pop with FIFO non-full as both performed; level unchanged.
REQ-022 The block SHALL wrap FIFO pointers modulo FIFO_DEPTH; level ranges 0..FIFO_DEPTH; ready=(level!=FIFO_DEPTH).
REQ-023 The block SHALL define busy=(state!=IDLE)|(level!=0).
REQ-024 The block SHALL ensure bytes leave in write order; none duplicated or lost except dropped-on-full.

Reset
REQ-025 The block SHALL set, when resetn=0 at a clock edge: tx_out=1, state=IDLE, level=0, ready=1, busy=0, overflow=0, pointers=0, bit counters=0.
REQ-026 The block SHALL let reset mid-frame abort the frame: tx_out=1 from the next edge, queued bytes discarded, no partial frame resumed.
REQ-027 The block SHALL clear overflow only by reset.

Verification
REQ-028 The bench SHALL, with SYSTEM_CLK=1_000_000, BAUDRATE=100_000 (CPS=10), write 0xA5 at edge N -> tx_out low at N+2; line 0,1,0,1,0,0,1,0,1,1 each 10 cycles; busy=0 at N+102.
REQ-029 The bench SHALL write 0x00, 0xFF, 0x55 on consecutive cycles -> three frames back-to-back, 300 cycles total, no idle gap, order preserved.
REQ-030 The bench SHALL fill with FIFO_DEPTH=4 while IDLE held off by continuous writes (5 writes starting at edge N) -> first byte popped at N+1, 5th accepted, 6th write at level=4 dropped, overflow=1, ready=0.
REQ-031 The bench SHALL write while level=FIFO_DEPTH on the same edge as a STOP-end pop -> write dropped, level=FIFO_DEPTH-1 after edge, overflow=1.
REQ-032 The bench SHALL assert resetn=0 for one cycle during DATA bit 3 with 2 bytes queued -> tx_out=1, level=0, busy=0 next edge; no further frames.
REQ-033 The bench SHALL loop back tx_out into the team's receiver (same parameters) with 256 random bytes -> all received in order, receiver error never asserted.
